// File: rtl/bus_sram_responder.sv
// Word-addressed SRAM slave on a multiplexed address/data bus.
// Reads stream a burst with two-cycle latency; writes are masked by byte lanes.
module bus_sram_responder #(
   parameter logic [31:0] baseAddress = 32'h00000000,
   parameter int unsigned addressBits = 10
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        beginTransactionIn,
   input  logic        endTransactionIn,
   input  logic        readNotWriteIn,
   input  logic        dataValidIn,
   input  logic        busyIn,
   input  logic [3:0]  byteEnablesIn,
   input  logic [7:0]  burstSizeIn,
   input  logic [31:0] addressDataIn,
   output logic        dataValidOut,
   output logic        endTransactionOut,
   output logic        busErrorOut,
   output logic [31:0] addressDataOut
);

   localparam int unsigned DEPTH   = 1 << addressBits;
   localparam logic [32:0] DEPTH33 = 33'd1 << addressBits;
   localparam logic [32:0] WINDOW  = 33'd4 << addressBits;

   typedef enum logic [2:0] {IDLE, READ, READ_END, WRITE, ERROR, WAIT_END} state_t;

   state_t                 state_q, state_d;
   logic [addressBits-1:0] addr_q, addr_d;
   logic [8:0]             cnt_q, cnt_d;
   logic [3:0]             be_q, be_d;
   logic                   dv_q, dv_d, end_q, end_d, err_q, err_d;
   logic [31:0]            data_q, data_d;
   logic [31:0]            mem [DEPTH];

   // A borrow from the subtraction lands in bit 32, which pushes any address
   // below the base outside the window with a single compare.
   logic [32:0]            offset;
   logic [32:0]            end_idx;
   logic [addressBits-1:0] start_idx;
   logic                   in_window, bad_start, mem_we;

   assign offset    = {1'b0, addressDataIn} - {1'b0, baseAddress};
   assign in_window = offset < WINDOW;
   assign start_idx = offset[addressBits+1:2];
   assign end_idx   = 33'(start_idx) + 33'(burstSizeIn) + 33'd1;
   assign bad_start = (offset[1:0] != 2'b00) || (end_idx > DEPTH33);
   assign mem_we    = (state_q == WRITE) && dataValidIn && (cnt_q != 9'd0);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      be_d    = be_q;
      dv_d    = 1'b0;
      data_d  = 32'h0;
      end_d   = 1'b0;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (beginTransactionIn && in_window) begin
               addr_d = start_idx;
               cnt_d  = 9'(burstSizeIn) + 9'd1;
               be_d   = byteEnablesIn;
               if (bad_start) begin
                  state_d = ERROR;
                  err_d   = 1'b1;
               end else begin
                  state_d = readNotWriteIn ? READ : WRITE;
               end
            end
         end
         READ: begin
            if (endTransactionIn) begin
               state_d = IDLE;
            end else if (dv_q && busyIn) begin
               dv_d   = dv_q;
               data_d = data_q;
            end else if (cnt_q != 9'd0) begin
               dv_d   = 1'b1;
               data_d = mem[addr_q];
               addr_d = addr_q + 1'b1;
               cnt_d  = cnt_q - 9'd1;
            end else begin
               state_d = READ_END;
               end_d   = 1'b1;
            end
         end
         READ_END: state_d = IDLE;
         WRITE: begin
            if (mem_we) begin
               addr_d = addr_q + 1'b1;
               cnt_d  = cnt_q - 9'd1;
            end
            // A closing beat may ride with endTransactionIn; only surplus beats fault.
            if (endTransactionIn) begin
               state_d = IDLE;
            end else if (dataValidIn && cnt_q == 9'd0) begin
               state_d = ERROR;
               err_d   = 1'b1;
            end
         end
         ERROR:    state_d = WAIT_END;
         WAIT_END: if (endTransactionIn) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         cnt_q   <= '0;
         be_q    <= '0;
         dv_q    <= 1'b0;
         end_q   <= 1'b0;
         err_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         be_q    <= be_d;
         dv_q    <= dv_d;
         end_q   <= end_d;
         err_q   <= err_d;
         data_q  <= data_d;
      end
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) mem[addr_q][8*i +: 8] <= addressDataIn[8*i +: 8];
         end
      end
   end

   assign dataValidOut      = dv_q;
   assign endTransactionOut = end_q;
   assign busErrorOut       = err_q;
   assign addressDataOut    = data_q;

endmodule

// File: tb/tb_bus_sram_responder.sv
// Randomised bench for bus_sram_responder: a word-array reference model feeds
// an expected-event queue that a negedge monitor drains as the bus responds.
module tb_bus_sram_responder;

   localparam logic [31:0] BASE  = 32'h0001_0000;
   localparam int          AB    = 6;
   localparam int          DEPTH = 1 << AB;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        beginTransactionIn, endTransactionIn, readNotWriteIn, dataValidIn, busyIn;
   logic [3:0]  byteEnablesIn;
   logic [7:0]  burstSizeIn;
   logic [31:0] addressDataIn;
   logic        dataValidOut, endTransactionOut, busErrorOut;
   logic [31:0] addressDataOut;

   always #5 clock = ~clock;

   bus_sram_responder #(.baseAddress(BASE), .addressBits(AB)) dut (
      .clock(clock), .reset(reset),
      .beginTransactionIn(beginTransactionIn), .endTransactionIn(endTransactionIn),
      .readNotWriteIn(readNotWriteIn), .dataValidIn(dataValidIn), .busyIn(busyIn),
      .byteEnablesIn(byteEnablesIn), .burstSizeIn(burstSizeIn), .addressDataIn(addressDataIn),
      .dataValidOut(dataValidOut), .endTransactionOut(endTransactionOut),
      .busErrorOut(busErrorOut), .addressDataOut(addressDataOut)
   );

   typedef enum int {EV_DATA, EV_END, EV_ERR} ev_kind_t;
   typedef struct { ev_kind_t kind; logic [31:0] data; } ev_t;

   ev_t         exp_q[$];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] wq[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          mon_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic expect_ev(input ev_kind_t k, input logic [31:0] d, input string name);
      ev_t e;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: got unexpected output (data %h), required nothing", name, d);
      end else begin
         e = exp_q.pop_front();
         check({name, "_kind"}, 32'(k), 32'(e.kind));
         if (k == EV_DATA && e.kind == EV_DATA) check(name, d, e.data);
      end
   endtask

   always @(negedge clock) begin
      if (mon_en && reset) begin
         if (!dataValidOut) check("bus_zero_when_idle", addressDataOut, 32'h0);
         if (dataValidOut && !busyIn) expect_ev(EV_DATA, addressDataOut, "read_data");
         if (endTransactionOut) expect_ev(EV_END, 32'h0, "end_pulse");
         if (busErrorOut) expect_ev(EV_ERR, 32'h0, "bus_error");
      end
   end

   // 0: not selected, 1: selected but faulting, 2: good transaction
   function automatic int classify(input logic [31:0] a, input int burst);
      longint off;
      off = longint'(a) - longint'(BASE);
      if (off < 0 || off >= 4 * DEPTH) return 0;
      if (off % 4 != 0 || off / 4 + burst + 1 > DEPTH) return 1;
      return 2;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic write_txn(input logic [31:0] addr, input logic [3:0] be, input int burst);
      int cls, nb, idx;
      bit clean;
      cls   = classify(addr, burst);
      nb    = wq.size();
      idx   = int'((longint'(addr) - longint'(BASE)) / 4);
      clean = (cls == 2) && (nb <= burst + 1);
      if (cls == 1) exp_q.push_back('{kind: EV_ERR, data: 32'h0});
      if (cls == 2) begin
         for (int i = 0; i < nb && i <= burst; i++) ref_mem[idx+i] = merge(ref_mem[idx+i], wq[i], be);
         if (nb > burst + 1) exp_q.push_back('{kind: EV_ERR, data: 32'h0});
      end
      beginTransactionIn = 1'b1; readNotWriteIn = 1'b0; byteEnablesIn = be;
      burstSizeIn = 8'(burst); addressDataIn = addr;
      step();
      beginTransactionIn = 1'b0;
      for (int i = 0; i < nb; i++) begin
         dataValidIn      = 1'b1;
         addressDataIn    = wq[i];
         endTransactionIn = clean && (i == nb - 1);
         step();
      end
      dataValidIn = 1'b0; endTransactionIn = 1'b0; addressDataIn = 32'h0;
      if (!clean) begin
         step(); step();
         endTransactionIn = 1'b1;
         step();
         endTransactionIn = 1'b0;
      end
   endtask

   // mode 0: random busy, 1: hold the second word for 3 busy cycles, 2: never busy
   task automatic read_txn(input logic [31:0] addr, input int burst, input int mode);
      int cls, idx, cyc, first, acc, held, shown2, last_cyc, end_cyc;
      logic [31:0] w2;
      bit done;
      cls = classify(addr, burst);
      cyc = 0; first = -1; acc = 0; held = 0; shown2 = 0; last_cyc = -1; end_cyc = -1; done = 1'b0;
      w2 = 32'h0;
      if (cls == 2) begin
         idx = int'((longint'(addr) - longint'(BASE)) / 4);
         for (int i = 0; i <= burst; i++) exp_q.push_back('{kind: EV_DATA, data: ref_mem[idx+i]});
         exp_q.push_back('{kind: EV_END, data: 32'h0});
      end else if (cls == 1) begin
         exp_q.push_back('{kind: EV_ERR, data: 32'h0});
      end
      beginTransactionIn = 1'b1; readNotWriteIn = 1'b1; burstSizeIn = 8'(burst);
      byteEnablesIn = 4'h0; addressDataIn = addr;
      step();
      beginTransactionIn = 1'b0; addressDataIn = 32'h0; cyc = 1;
      if (cls != 2) begin
         repeat (2) begin
            if (cls == 0) check("unselected_quiet", {29'd0, dataValidOut, endTransactionOut, busErrorOut}, 32'h0);
            step();
         end
         endTransactionIn = 1'b1;
         step();
         endTransactionIn = 1'b0;
         return;
      end
      for (int k = 0; k < 600 && !done; k++) begin
         if (dataValidOut && first < 0) first = cyc;
         busyIn = 1'b0;
         if (mode == 0) begin
            busyIn = ($urandom_range(0, 3) == 0);
         end else if (mode == 1 && dataValidOut && acc == 1) begin
            if (shown2 == 0) w2 = addressDataOut;
            else check("busy_hold_data", addressDataOut, w2);
            shown2++;
            busyIn = (held < 3);
            if (busyIn) held++;
         end
         if (endTransactionOut) begin
            done = 1'b1; busyIn = 1'b0; end_cyc = cyc;
         end
         if (dataValidOut && !busyIn) begin
            acc++;
            if (acc == burst + 1) last_cyc = cyc;
         end
         step();
         cyc++;
      end
      busyIn = 1'b0;
      if (!done) begin
         n_cmp++; n_bad++;
         $display("FAIL read_timeout: got no endTransactionOut in 600 cycles, required one");
      end
      check("read_latency", 32'(first), 32'd2);
      check("read_beats", 32'(acc), 32'(burst + 1));
      check("end_after_last", 32'(end_cyc - last_cyc), 32'd1);
      if (mode == 1) check("busy_hold_cycles", 32'(shown2), 32'd4);
   endtask

   int          sel, ridx, rburst, nb;
   logic [31:0] a;

   initial begin
      beginTransactionIn = 1'b0; endTransactionIn = 1'b0; readNotWriteIn = 1'b0;
      dataValidIn = 1'b0; busyIn = 1'b0; byteEnablesIn = 4'h0; burstSizeIn = 8'h0;
      addressDataIn = 32'h0;
      repeat (3) @(posedge clock);
      #1;
      check("reset_ctrl", {29'd0, dataValidOut, endTransactionOut, busErrorOut}, 32'h0);
      check("reset_data", addressDataOut, 32'h0);
      reset = 1'b1;
      step();
      mon_en = 1'b1;

      // Preload every word with a full-lane burst so the model knows all contents.
      wq.delete();
      for (int i = 0; i < DEPTH; i++) wq.push_back($urandom());
      write_txn(BASE, 4'hF, DEPTH - 1);
      read_txn(BASE, DEPTH - 1, 2);

      wq = {32'd1, 32'd2, 32'd3, 32'd4};
      write_txn(BASE + 32'h10, 4'hF, 3);
      read_txn(BASE + 32'h10, 3, 2);

      wq = {32'h11223344};
      write_txn(BASE + 32'h40, 4'hF, 0);
      wq = {32'hAABBCCDD};
      write_txn(BASE + 32'h40, 4'b0010, 0);
      read_txn(BASE + 32'h40, 0, 2);

      read_txn(BASE, 3, 1);

      read_txn(BASE + 32'(4 * (DEPTH - 1)), 1, 2);
      read_txn(BASE + 32'(4 * (DEPTH - 1)), 0, 2);
      read_txn(BASE - 32'd4, 0, 2);
      read_txn(BASE + 32'(4 * DEPTH), 0, 2);
      read_txn(BASE + 32'd2, 0, 2);

      wq = {32'hCAFE0001, 32'hCAFE0002};
      write_txn(BASE + 32'h80, 4'hF, 0);
      read_txn(BASE + 32'h80, 1, 2);

      // Abort a running read from the initiator side.
      mon_en = 1'b0;
      beginTransactionIn = 1'b1; readNotWriteIn = 1'b1; burstSizeIn = 8'd5; addressDataIn = BASE;
      step();
      beginTransactionIn = 1'b0; addressDataIn = 32'h0;
      step(); step();
      check("abort_pre_valid", 32'(dataValidOut), 32'd1);
      endTransactionIn = 1'b1;
      step();
      endTransactionIn = 1'b0;
      check("abort_ctrl", {29'd0, dataValidOut, endTransactionOut, busErrorOut}, 32'h0);
      check("abort_data", addressDataOut, 32'h0);
      step();

      // Asynchronous reset in the middle of a read.
      beginTransactionIn = 1'b1; readNotWriteIn = 1'b1; burstSizeIn = 8'd7; addressDataIn = BASE + 32'h20;
      step();
      beginTransactionIn = 1'b0; addressDataIn = 32'h0;
      repeat (3) step();
      #2 reset = 1'b0;
      #1;
      check("async_reset_ctrl", {29'd0, dataValidOut, endTransactionOut, busErrorOut}, 32'h0);
      check("async_reset_data", addressDataOut, 32'h0);
      repeat (2) step();
      check("reset_held_ctrl", {29'd0, dataValidOut, endTransactionOut, busErrorOut}, 32'h0);
      #3 reset = 1'b1;
      step();
      mon_en = 1'b1;
      read_txn(BASE + 32'h20, 7, 2);

      for (int t = 0; t < 40; t++) begin
         sel    = $urandom_range(0, 9);
         ridx   = $urandom_range(0, DEPTH - 1);
         rburst = $urandom_range(0, 7);
         a      = BASE + 32'(ridx * 4);
         if (sel == 0) a = a + 32'($urandom_range(1, 3));
         else if (sel == 1) a = ($urandom_range(0, 1) == 1) ? BASE - 32'($urandom_range(1, 64))
                                                             : BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 64));
         if ($urandom_range(0, 1) == 1) begin
            read_txn(a, rburst, 0);
         end else begin
            nb = (sel == 2) ? rburst + 2 : $urandom_range(1, rburst + 1);
            wq.delete();
            for (int i = 0; i < nb; i++) wq.push_back($urandom());
            write_txn(a, 4'($urandom_range(1, 15)), rburst);
         end
      end
      read_txn(BASE, DEPTH - 1, 0);

      repeat (5) step();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bus_sram_responder.md
BUS_SRAM_RESPONDER -- requirements
Module: bus_sram_responder

Interface
REQ-001 The block SHALL have a parameter baseAddress, default 32'h00000000, giving the bus byte address of memory word 0.
REQ-002 The block SHALL have a parameter addressBits, default 10, giving memory depth as 2^addressBits 32-bit words.
REQ-003 Port clock, input, 1, single system clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1, asynchronous, active-low reset.
REQ-005 Port beginTransactionIn, input, 1, start of a bus transaction, with the address on addressDataIn.
REQ-006 Port endTransactionIn, input, 1, initiator terminates the current transaction.
REQ-007 Port readNotWriteIn, input, 1, transaction direction, sampled with beginTransactionIn.
REQ-008 Port dataValidIn, input, 1, write data word present on addressDataIn.
REQ-009 Port busyIn, input, 1, initiator cannot accept read data this cycle.
REQ-010 Port byteEnablesIn, input, 4, byte lanes for writes, sampled with beginTransactionIn.
REQ-011 Port burstSizeIn, input, 8, burst length minus one, sampled with beginTransactionIn.
REQ-012 Port addressDataIn, input, 32, multiplexed address and write data.
REQ-013 Port dataValidOut, output, 1, read data word present on addressDataOut.
REQ-014 Port endTransactionOut, output, 1, responder terminates the transaction.
REQ-015 Port busErrorOut, output, 1, transaction error.
REQ-016 Port addressDataOut, output, 32, read data.

Function
REQ-017 All outputs SHALL be registered and SHALL be 0 whenever the block is not driving them, so they can be OR-combined on the bus.
REQ-018 The block SHALL implement these states: IDLE, READ, READ_END, WRITE, ERROR, WAIT_END.
REQ-019 In IDLE, a beginTransactionIn with addressDataIn inside [baseAddress, baseAddress + 4*2^addressBits) SHALL select the block; it SHALL capture the word index (addressDataIn - baseAddress) >> 2, burstSizeIn, byteEnablesIn and readNotWriteIn.
REQ-020 In IDLE, a beginTransactionIn with an address outside that window SHALL be ignored, and all outputs SHALL stay 0.
REQ-021 A selected transaction SHALL go to ERROR if addressDataIn[1:0] != 0, or if word index + burstSize + 1 > 2^addressBits; otherwise it SHALL go to READ or WRITE according to readNotWriteIn.
REQ-022 READ latency: the first dataValidOut SHALL be asserted exactly 2 cycles after the cycle in which beginTransactionIn is sampled.
REQ-023 In READ, burstSize+1 consecutive words SHALL be returned from incrementing word addresses, one per cycle.
REQ-024 In READ, while busyIn is 1, dataValidOut and addressDataOut SHALL hold their values and the address and word count SHALL not advance.
REQ-025 After the last read word has been accepted (busyIn 0), the block SHALL enter READ_END and assert endTransactionOut for exactly 1 cycle, then return to IDLE.
REQ-026 In WRITE, each dataValidIn SHALL write addressDataIn to the current word under the captured byteEnables (lane i covers bits 8i+7:8i), then increment the word address.
REQ-027 In WRITE, endTransactionIn SHALL return the block to IDLE; endTransactionIn together with dataValidIn in the same cycle SHALL still perform that write.
REQ-028 In WRITE, a dataValidIn beyond burstSize+1 words SHALL not be written and SHALL move the block to ERROR.
REQ-029 In ERROR, busErrorOut SHALL be asserted for 1 cycle, then the block SHALL go to WAIT_END.
REQ-030 In WAIT_END, the block SHALL stay until endTransactionIn, then go to IDLE; no memory write SHALL occur in ERROR or WAIT_END.
REQ-031 endTransactionIn received during READ SHALL abort the read: outputs go to 0 next cycle and the state returns to IDLE.
REQ-032 beginTransactionIn received in any state other than IDLE SHALL be ignored.
REQ-033 The word address SHALL be addressBits wide; because of REQ-021 it never wraps.

Reset
REQ-034 On assertion of reset (reset = 0), asynchronously: state SHALL be IDLE, all outputs and counters SHALL be 0, and memory contents SHALL be retained but are undefined after power-up.
REQ-035 Reset asserted in the middle of a transaction SHALL abandon it without asserting endTransactionOut or busErrorOut.

Verification
REQ-036 Write then read: write burst at baseAddress+0x10, burstSize 3, data 1..4, byteEnables F -> read back with burstSize 3 returns 1,2,3,4; first dataValidOut at cycle 2 after begin; endTransactionOut 1 cycle after the word with value 4.
REQ-037 Partial write: byteEnables 4'b0010, data 32'hAABBCCDD over word 32'h11223344 -> read returns 32'h1122CC44.
REQ-038 busyIn during read: busyIn held high for 3 cycles on the second word -> the same word is held for 4 cycles and all 4 words are delivered in order.
REQ-039 Error cases: burst at the last word with burstSize 1 -> exactly one busErrorOut pulse, no dataValidOut; out-of-window address -> all outputs remain 0.
REQ-040 Write overrun: burstSize 0 with two dataValidIn -> only the first word is written, busErrorOut pulses, and the block waits for endTransactionIn.
REQ-041 Async reset mid-read -> all outputs go to 0 immediately; a new transaction after reset completes normally.
